psrch_ctrl: RTL and testbench

- Hardware sequencer for the program-3 pattern search, and the bus master of data memory while it runs.
- On a `req` pulse it reads the 5-bit pattern from `PAT_ADDR` and scans `NUM_BYTES` message bytes.
- It computes three counts: within-byte matches, matching bytes, and bit-stream matches. It writes them to `RES_ADDR`..`RES_ADDR+2`, then raises `done`.
- Sits beside the core and drives the dm1 port when granted.

---
 rtl/psrch_pkg.sv | 30 +++
 rtl/psrch_win_cnt.sv | 49 ++++
 rtl/psrch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_psrch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/psrch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psrch_pkg
//  Purpose  : Shared types and constants for the pattern-search sequencer.
//             The FSM state enum, pattern field position and width, count
//             width, and result-slot offsets.
//  Revision : 1.0  initial release
// ============================================================================
package psrch_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LDPAT  = 3'd1,
        S_SCAN   = 3'd2,
        S_WR_CTB = 3'd3,
        S_WR_CTO = 3'd4,
        S_WR_CTS = 3'd5,
        S_DONE   = 3'd6
    } psrch_state_t;

    localparam int PAT_LSB = 3;     // pattern occupies bits [7:3] of its byte
    localparam int PAT_W   = 5;
    localparam int CNT_W   = 8;

    localparam int OFF_CTB = 0;
    localparam int OFF_CTO = 1;
    localparam int OFF_CTS = 2;

endpackage : psrch_pkg
`default_nettype wire

// File: rtl/psrch_win_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : psrch_win_cnt
//  Purpose  : Combinational 5-bit window matcher for one message byte.
//  Ports    : i_prev_nib  low nibble of the previous byte
//             i_byte      current byte
//             i_pat       5-bit pattern
//             i_first     current byte is byte 0 (no predecessor)
//             o_m         matches among the 4 windows inside i_byte (0..4)
//             o_stream    bit-stream matches contributed by this byte (0..8)
//  Revision : 1.0  initial release
// ============================================================================
module psrch_win_cnt
    import psrch_pkg::*;
(
    input  logic [3:0]       i_prev_nib,
    input  logic [7:0]       i_byte,
    input  logic [PAT_W-1:0] i_pat,
    input  logic             i_first,
    output logic [2:0]       o_m,
    output logic [3:0]       o_stream
);

    logic [11:0] w_win;
    logic [2:0]  w_m;
    logic [3:0]  w_all;

    assign w_win = {i_prev_nib, i_byte};

    // Windows starting at bit 0..3 lie wholly inside the byte; windows
    // starting at bit 4..7 straddle the boundary with the previous byte.
    always_comb begin
        w_m   = 3'd0;
        w_all = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_win[k +: PAT_W] == i_pat) begin
                w_all = w_all + 4'd1;
                if (k < 4) begin
                    w_m = w_m + 3'd1;
                end
            end
        end
    end

    assign o_m      = w_m;
    assign o_stream = i_first ? {1'b0, w_m} : w_all;

endmodule : psrch_win_cnt
`default_nettype wire

// File: rtl/psrch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psrch_ctrl
//  Purpose  : Pattern-search sequencer and data-memory master. On req it
//             loads the pattern byte, scans NUM_BYTES message bytes one per
//             cycle, writes ctb/cto/cts to RES_ADDR..RES_ADDR+2, then holds
//             done until the next accepted req.
//  Ports    : clk, reset (sync, active-low), req, done, busy,
//             mem_addr, mem_rd_data (combinational read), mem_wr_en,
//             mem_wr_data, perf_cycles (only with PSRCH_PERF_EN)
//  Options  : `define PSRCH_PERF_EN adds perf_cycles, the number of clock
//             edges spent busy in the last run.
//  Revision : 1.0  initial release
// ============================================================================
module psrch_ctrl
    import psrch_pkg::*;
#(
    parameter int NUM_BYTES = 32,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
`ifdef PSRCH_PERF_EN
    ,
    output logic [7:0]    perf_cycles
`endif
);

    psrch_state_t     r_state, w_next;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_ctb, r_cto, r_cts;
    logic [3:0]       r_prev_nib;
    logic [AW-1:0]    r_idx;

    logic [2:0]       w_m;
    logic [3:0]       w_stream;
    logic             w_accept;
    logic             w_last;

    assign w_accept = req && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == AW'(NUM_BYTES - 1));

    psrch_win_cnt u_win_cnt (
        .i_prev_nib (r_prev_nib),
        .i_byte     (mem_rd_data),
        .i_pat      (r_pat),
        .i_first    (r_idx == '0),
        .o_m        (w_m),
        .o_stream   (w_stream)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) w_next = S_LDPAT;
            end
            S_LDPAT: begin
                mem_addr = AW'(PAT_ADDR);
                w_next   = S_SCAN;
            end
            S_SCAN: begin
                mem_addr = r_idx;
                if (w_last) w_next = S_WR_CTB;
            end
            S_WR_CTB: begin
                mem_addr    = AW'(RES_ADDR + OFF_CTB);
                mem_wr_en   = 1'b1;
                mem_wr_data = r_ctb;
                w_next      = S_WR_CTO;
            end
            S_WR_CTO: begin
                mem_addr    = AW'(RES_ADDR + OFF_CTO);
                mem_wr_en   = 1'b1;
                mem_wr_data = r_cto;
                w_next      = S_WR_CTS;
            end
            S_WR_CTS: begin
                mem_addr    = AW'(RES_ADDR + OFF_CTS);
                mem_wr_en   = 1'b1;
                mem_wr_data = r_cts;
                w_next      = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (w_accept) w_next = S_LDPAT;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pattern latch, byte index, running counts
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pat      <= '0;
            r_ctb      <= '0;
            r_cto      <= '0;
            r_cts      <= '0;
            r_prev_nib <= '0;
            r_idx      <= '0;
        end else if (w_accept) begin
            r_ctb      <= '0;
            r_cto      <= '0;
            r_cts      <= '0;
            r_prev_nib <= '0;
            r_idx      <= '0;
        end else if (r_state == S_LDPAT) begin
            r_pat <= mem_rd_data[PAT_LSB +: PAT_W];
            r_idx <= '0;
        end else if (r_state == S_SCAN) begin
            r_ctb      <= r_ctb + CNT_W'(w_m);
            r_cto      <= r_cto + CNT_W'(w_m != 3'd0);
            r_cts      <= r_cts + CNT_W'(w_stream);
            r_prev_nib <= mem_rd_data[3:0];
            r_idx      <= r_idx + AW'(1);
        end
    end

`ifdef PSRCH_PERF_EN
    logic [7:0] r_perf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf <= 8'd0;
        end else if (w_accept) begin
            r_perf <= 8'd0;
        end else if (busy) begin
            r_perf <= r_perf + 8'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule : psrch_ctrl
`default_nettype wire

// File: tb/tb_psrch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psrch_ctrl
//  Purpose  : Self-checking bench for psrch_ctrl with a behavioural data
//             memory. Expected result writes are queued by the stimulus
//             and popped/compared by an independent write monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psrch_ctrl;

    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          req;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
`ifdef PSRCH_PERF_EN
    logic [7:0]    perf_cycles;
`endif

    logic [7:0] mem [0:255];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q_exp[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   wr_count = 0;

    psrch_ctrl #(
        .NUM_BYTES (32),
        .PAT_ADDR  (32),
        .RES_ADDR  (33),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef PSRCH_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Write monitor: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        if (reset && mem_wr_en) begin
            wr_count++;
            if (q_exp.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("wr_addr", int'(mem_addr), int'(e.addr));
                check("wr_data", int'(mem_wr_data), int'(e.data));
            end
        end
    end

    task automatic fill(input logic [7:0] val, input logic [7:0] pat);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int a = 0; a < 32; a++) mem[a] = val;
        mem[32] = pat;
    endtask

    // Called at posedge+1. Issues req, waits for done, checks latency.
    // glitch_at > 0 pulses req once while the run is in progress.
    task automatic run_op(input int e_ctb, input int e_cto, input int e_cts,
                          input int glitch_at);
        int n;
        int wr0;
        exp_t e;
        e.addr = 8'd33; e.data = 8'(e_ctb); q_exp.push_back(e);
        e.addr = 8'd34; e.data = 8'(e_cto); q_exp.push_back(e);
        e.addr = 8'd35; e.data = 8'(e_cts); q_exp.push_back(e);
        wr0 = wr_count;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        check("done_clear_on_req", int'(done), 0);
        check("busy_after_req", int'(busy), 1);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            req = (n == glitch_at);
            if (done) break;
        end
        req = 1'b0;
        check("done_latency", n, 36);
        check("busy_in_done", int'(busy), 0);
        check("write_burst_len", wr_count - wr0, 3);
        check("scoreboard_empty", q_exp.size(), 0);
        check("mem_ctb", int'(mem[33]), e_ctb);
        check("mem_cts", int'(mem[35]), e_cts);
`ifdef PSRCH_PERF_EN
        check("perf_cycles", int'(perf_cycles), 36);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int wr0;
        reset = 1'b0;
        req   = 1'b0;
        fill(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // All zero, pattern 00000
        fill(8'h00, 8'h00);
        run_op(128, 32, 252, 0);
        // All ones, pattern 11111
        fill(8'hFF, 8'hF8);
        run_op(128, 32, 252, 0);
        // Alternating bits, pattern 10101
        fill(8'h55, 8'hA8);
        run_op(64, 32, 126, 0);
        // Match exists only across the byte0/byte1 boundary
        fill(8'h00, 8'hF8);
        mem[0] = 8'h03;
        mem[1] = 8'hE0;
        run_op(0, 0, 1, 0);

        // Abort with reset while scanning byte 10
        fill(8'h55, 8'hA8);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("abort_scan_addr", int'(mem_addr), 10);
        wr0 = wr_count;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_writes", wr_count - wr0, 0);
        check("abort_idle_busy", int'(busy), 0);
        run_op(64, 32, 126, 0);

        // req during SCAN is ignored; then req in DONE repeats the run
        fill(8'h00, 8'hF8);
        mem[0] = 8'h03;
        mem[1] = 8'hE0;
        run_op(0, 0, 1, 10);
        run_op(0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_psrch_ctrl
`default_nettype wire
